// File: rtl/ysyx_23060042_exu_mc.sv
// Multi-cycle execute stage with valid/ready on both sides.
// ALU and branch ops finish in one cycle; MUL/MULHU iterate XLEN cycles.
module ysyx_23060042_exu_mc #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_sel_pc,
    input  logic            in_sel_imm,
    input  logic            in_brch,
    input  logic [2:0]      in_brop,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_wdata,
    output logic [4:0]      out_rd,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            busy
);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN - 1);
    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(XLEN);

    state_t              state;
    logic [SHW:0]        cnt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     ma;
    logic [XLEN-1:0]     mb;
    logic                mhi;
    logic [4:0]          mrd;

    logic                free;
    logic                accept;
    logic                is_mul;
    logic [XLEN-1:0]     opa;
    logic [XLEN-1:0]     opb;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     alu_res;
    logic                br_take;
    logic                last;
    logic                done;
    logic [2*XLEN-1:0]   mul_add;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN-1:0]     mul_res;

    assign free     = !out_valid || out_ready;
    assign in_ready = !rst && (state == IDLE) && free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = !in_brch && (in_op == 4'd10 || in_op == 4'd11);

    assign opa   = in_sel_pc  ? in_pc  : in_src1;
    assign opb   = in_sel_imm ? in_imm : in_src2;
    assign shamt = opb[SHW-1:0];

    // single-cycle ALU result; MUL ops and reserved codes yield 0 here
    always_comb begin
        alu_res = '0;
        case (in_op)
            4'd0:    alu_res = opa + opb;
            4'd1:    alu_res = opa - opb;
            4'd2:    alu_res = opa & opb;
            4'd3:    alu_res = opa | opb;
            4'd4:    alu_res = opa ^ opb;
            4'd5:    alu_res = opa << shamt;
            4'd6:    alu_res = opa >> shamt;
            4'd7:    alu_res = $signed(opa) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}},
                                $signed(opa) < $signed(opb)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, opa < opb};
            default: alu_res = '0;
        endcase
    end

    // branch condition always compares the raw register operands
    always_comb begin
        br_take = 1'b0;
        case (in_brop)
            3'd0:    br_take = in_src1 == in_src2;
            3'd1:    br_take = in_src1 != in_src2;
            3'd4:    br_take = $signed(in_src1) < $signed(in_src2);
            3'd5:    br_take = $signed(in_src1) >= $signed(in_src2);
            3'd6:    br_take = in_src1 < in_src2;
            3'd7:    br_take = in_src1 >= in_src2;
            default: br_take = 1'b0;
        endcase
    end

    // one shift-add step; once saturated the accumulator is final
    assign last    = cnt == CNT_LAST;
    assign done    = cnt == CNT_DONE;
    assign mul_add = (!done && mb[cnt[SHW-1:0]])
                   ? ({{XLEN{1'b0}}, ma} << cnt[SHW-1:0])
                   : '0;
    assign mul_nxt = acc + mul_add;
    assign mul_res = mhi ? mul_nxt[2*XLEN-1:XLEN] : mul_nxt[XLEN-1:0];

    // FSM, multiplier state and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            ma         <= '0;
            mb         <= '0;
            mhi        <= 1'b0;
            mrd        <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_wdata  <= '0;
            out_rd     <= '0;
            out_taken  <= 1'b0;
            out_target <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            ma    <= opa;
                            mb    <= opb;
                            mhi   <= in_op[0];
                            mrd   <= in_rd;
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= MUL;
                        end else begin
                            out_valid  <= 1'b1;
                            out_wdata  <= in_brch
                                        ? in_pc + XLEN'(4)
                                        : alu_res;
                            out_rd     <= in_brch ? 5'd0 : in_rd;
                            out_taken  <= in_brch && br_take;
                            out_target <= in_pc + in_imm;
                        end
                    end
                end
                MUL: begin
                    if (last || done) begin
                        if (free) begin
                            out_valid  <= 1'b1;
                            out_wdata  <= mul_res;
                            out_rd     <= mrd;
                            out_taken  <= 1'b0;
                            out_target <= '0;
                            cnt        <= '0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            acc  <= mul_nxt;
                            cnt  <= CNT_DONE;
                            busy <= 1'b0;
                        end
                    end else begin
                        acc <= mul_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060042_exu_mc.sv
// Directed bench for the multi-cycle execute stage.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_ysyx_23060042_exu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [3:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_imm;
    logic        in_sel_pc;
    logic        in_sel_imm;
    logic        in_brch;
    logic [2:0]  in_brop;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wdata;
    logic [4:0]  out_rd;
    logic        out_taken;
    logic [31:0] out_target;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int seen;

    ysyx_23060042_exu_mc #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_imm     (in_imm),
        .in_sel_pc  (in_sel_pc),
        .in_sel_imm (in_sel_imm),
        .in_brch    (in_brch),
        .in_brop    (in_brop),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_wdata  (out_wdata),
        .out_rd     (out_rd),
        .out_taken  (out_taken),
        .out_target (out_target),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_brch    = 1'b0;
        in_brop    = 3'd0;
        in_sel_pc  = 1'b0;
        in_sel_imm = 1'b0;
        in_pc      = 32'h0000_1000;
        in_imm     = 32'h0;
        in_op      = op;
        in_src1    = a;
        in_src2    = b;
        in_rd      = rd;
    endtask

    task automatic drive_br(input logic [2:0] brop, input logic [31:0] a,
                            input logic [31:0] b);
        in_valid   = 1'b1;
        in_brch    = 1'b1;
        in_brop    = brop;
        in_op      = 4'd0;
        in_sel_pc  = 1'b0;
        in_sel_imm = 1'b0;
        in_pc      = 32'h8000_0000;
        in_imm     = 32'hFFFF_FFF8;
        in_src1    = a;
        in_src2    = b;
        in_rd      = 5'd7;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive_alu(4'd0, 32'h0, 32'h0, 5'd0);
        in_valid  = 1'b0;
        step();
        step();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wdata", out_wdata, 32'd0);
        rst = 1'b0;
        step();

        // ADD wraps
        drive_alu(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd5);
        #1;
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_wdata", out_wdata, 32'h0);
        chk("add_rd", {27'b0, out_rd}, 32'd5);

        // SRA by imm, only low 5 bits of shift used
        drive_alu(4'd7, 32'h8000_0000, 32'h0, 5'd6);
        in_sel_imm = 1'b1;
        in_imm     = 32'h21;
        step();
        chk("sra", out_wdata, 32'hC000_0000);

        drive_alu(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd6);
        step();
        chk("slt", out_wdata, 32'd1);
        drive_alu(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd6);
        step();
        chk("sltu", out_wdata, 32'd0);

        // branches LT / LTU
        drive_br(3'd4, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("blt_taken", {31'b0, out_taken}, 32'd1);
        chk("blt_target", out_target, 32'h7FFF_FFF8);
        chk("blt_wdata", out_wdata, 32'h8000_0004);
        chk("blt_rd", {27'b0, out_rd}, 32'd0);
        drive_br(3'd6, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("bltu_taken", {31'b0, out_taken}, 32'd0);

        // MUL low half: exact latency, in_ready low throughout
        drive_alu(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("mul_busy", {31'b0, busy}, 32'd1);
            chk("mul_nready", {31'b0, in_ready}, 32'd0);
            chk("mul_nvalid", {31'b0, out_valid}, 32'd0);
            step();
        end
        chk("mul_valid", {31'b0, out_valid}, 32'd1);
        chk("mul_wdata", out_wdata, 32'h0000_0001);
        chk("mul_rd", {27'b0, out_rd}, 32'd11);
        chk("mul_idle", {31'b0, busy}, 32'd0);

        // MULHU
        drive_alu(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
        step();
        in_valid = 1'b0;
        repeat (32) step();
        chk("mulhu_valid", {31'b0, out_valid}, 32'd1);
        chk("mulhu_wdata", out_wdata, 32'hFFFF_FFFE);
        step();
        chk("drain", {31'b0, out_valid}, 32'd0);

        // backpressure
        out_ready = 1'b0;
        drive_alu(4'd0, 32'd3, 32'd4, 5'd9);
        step();
        drive_alu(4'd0, 32'd10, 32'd20, 5'd10);
        in_pc  = 32'h8000_0000;
        in_imm = 32'h21;
        for (int i = 0; i < 5; i++) begin
            chk("bp_nready", {31'b0, in_ready}, 32'd0);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_wdata", out_wdata, 32'd7);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_wdata", out_wdata, 32'd30);
        chk("bp_next_rd", {27'b0, out_rd}, 32'd10);

        // back-to-back stream
        for (int k = 0; k < 8; k++) begin
            drive_alu(4'd0, 32'(k * 16), 32'(k + 1), 5'(k + 1));
            step();
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_wdata", out_wdata, 32'(17 * k + 1));
            chk("stream_rd", {27'b0, out_rd}, 32'(k + 1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end", {31'b0, out_valid}, 32'd0);

        // reset in the middle of a multiply
        drive_alu(4'd10, 32'd3, 32'd5, 5'd13);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_ready", {31'b0, in_ready}, 32'd0);
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_wdata", out_wdata, 32'd0);
        chk("mrst_rd", {27'b0, out_rd}, 32'd0);
        chk("mrst_target", out_target, 32'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid || busy) seen++;
        end
        chk("no_stale", 32'(seen), 32'd0);
        drive_alu(4'd0, 32'd2, 32'd2, 5'd3);
        step();
        in_valid = 1'b0;
        chk("post_valid", {31'b0, out_valid}, 32'd1);
        chk("post_wdata", out_wdata, 32'd4);
        chk("post_rd", {27'b0, out_rd}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
